// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared state encoding and default widths for the pulse train generator
package pulse_gen_pkg;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_NUM_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} pg_state_t;
endpackage

// File: rtl/pulse_phase_counter.sv
// pulse_phase_counter: loadable down-counter with zero flag, saturating at zero
module pulse_phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable HIGH/LOW pulse train with registered rise/fall strobes
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             wave_out,
    output logic             rise_strobe,
    output logic             fall_strobe,
    output logic             busy,
    output logic             done
);
    pg_state_t state, state_n;
    logic [NUM_W-1:0] left, left_n;
    logic [CNT_W-1:0] h_lat, l_lat, h_n, l_n, h_eff, l_eff, load_val;
    logic load, dec, zero;
    logic wave_n, rise_n, fall_n, busy_n, done_n;

    assign h_eff = (high_cycles == '0) ? CNT_W'(1) : high_cycles;
    assign l_eff = (low_cycles == '0) ? CNT_W'(1) : low_cycles;

    pulse_phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dec      (dec),
        .load_val (load_val),
        .zero     (zero)
    );

    always_comb begin
        state_n  = state;
        left_n   = left;
        h_n      = h_lat;
        l_n      = l_lat;
        load     = 1'b0;
        dec      = 1'b0;
        load_val = '0;
        wave_n   = 1'b0;
        rise_n   = 1'b0;
        fall_n   = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    h_n = h_eff;
                    l_n = l_eff;
                    if (num_pulses == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n  = HIGH;
                        left_n   = num_pulses;
                        load     = 1'b1;
                        load_val = h_eff - CNT_W'(1);
                        wave_n   = 1'b1;
                        rise_n   = 1'b1;
                        busy_n   = 1'b1;
                    end
                end
            end
            HIGH: begin
                // abort still closes the open high phase with a fall strobe
                if (abort) begin
                    state_n = IDLE;
                    fall_n  = 1'b1;
                end else if (zero) begin
                    state_n  = LOW;
                    load     = 1'b1;
                    load_val = l_lat - CNT_W'(1);
                    fall_n   = 1'b1;
                    busy_n   = 1'b1;
                end else begin
                    dec    = 1'b1;
                    wave_n = 1'b1;
                    busy_n = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (zero && left > NUM_W'(1)) begin
                    state_n  = HIGH;
                    left_n   = left - NUM_W'(1);
                    load     = 1'b1;
                    load_val = h_lat - CNT_W'(1);
                    wave_n   = 1'b1;
                    rise_n   = 1'b1;
                    busy_n   = 1'b1;
                end else if (zero) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    dec    = 1'b1;
                    busy_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            left        <= '0;
            h_lat       <= '0;
            l_lat       <= '0;
            wave_out    <= 1'b0;
            rise_strobe <= 1'b0;
            fall_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            left        <= left_n;
            h_lat       <= h_n;
            l_lat       <= l_n;
            wave_out    <= wave_n;
            rise_strobe <= rise_n;
            fall_strobe <= fall_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed and randomized trains checked against a cycle-indexed waveform model
module tb_pulse_train_gen;
    logic clk = 1'b0;
    logic rst, start, abort;
    logic [7:0] high_cycles, low_cycles, num_pulses;
    logic wave_out, rise_strobe, fall_strobe, busy, done;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_train_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .num_pulses  (num_pulses),
        .wave_out    (wave_out),
        .rise_strobe (rise_strobe),
        .fall_strobe (fall_strobe),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // wave level of an unaborted train in cycle j (cycle 1 = first cycle after start is taken)
    function automatic bit wave_ref(int h, int l, int n, int j);
        return j >= 1 && j <= n * (h + l) && ((j - 1) % (h + l)) < h;
    endfunction

    // expected {wave, rise, fall, busy, done}; ab = cycle in which abort is held, -1 for none
    function automatic logic [4:0] exp_vec(int h, int l, int n, int ab, int k);
        int t = n * (h + l) + 1;
        int p;
        if (ab >= 0 && ab <= t - 1 && k > ab)
            return (k == ab + 1) ? {2'b00, wave_ref(h, l, n, ab), 2'b00} : 5'b0;
        if (k == t) return 5'b00001;
        if (k > t) return 5'b0;
        p = (k - 1) % (h + l);
        return {p < h, p == 0, p == h, 1'b1, 1'b0};
    endfunction

    function automatic logic [4:0] outs();
        return {wave_out, rise_strobe, fall_strobe, busy, done};
    endfunction

    // entered just after a rising edge; cycle 0 is the current cycle
    task automatic run_train(input int hi, input int lo, input int n, input int ab, input bit spam);
        int h = (hi == 0) ? 1 : hi;
        int l = (lo == 0) ? 1 : lo;
        int t = n * (h + l) + 1;
        int lim = (ab >= 0 && ab + 1 < t) ? ab + 1 : t;
        high_cycles = 8'(hi);
        low_cycles  = 8'(lo);
        num_pulses  = 8'(n);
        start = 1'b1;
        abort = (ab == 0);
        for (int k = 1; k <= t + 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("h%0d_l%0d_n%0d_ab%0d_c%0d", hi, lo, n, ab, k), 32'(outs()), 32'(exp_vec(h, l, n, ab, k)));
            abort = (k == ab);
            start = spam && k < lim && (k == 4 || $urandom_range(0, 2) == 0);
            high_cycles = spam ? 8'($urandom_range(0, 3)) : high_cycles;
            low_cycles  = spam ? 8'($urandom_range(0, 3)) : low_cycles;
            num_pulses  = spam ? 8'($urandom_range(0, 12)) : num_pulses;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        high_cycles = '0;
        low_cycles = '0;
        num_pulses = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(outs()), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_train(2, 3, 3, -1, 1'b0);
        run_train(5, 2, 0, -1, 1'b0);
        run_train(0, 0, 4, -1, 1'b0);
        run_train(4, 4, 5, 10, 1'b0);
        run_train(3, 3, 2, -1, 1'b1);
        run_train(3, 2, 2, 0, 1'b0);
        run_train(1, 2, 2, 6, 1'b0);
        // async reset in the middle of a high phase, between edges
        high_cycles = 8'd5;
        low_cycles = 8'd2;
        num_pulses = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("pre_rst_high", 32'(outs()), 32'b11010);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle_after_rst_%0d", i), 32'(outs()), 32'd0);
        end
        run_train(1, 1, 1, -1, 1'b0);
        for (int r = 0; r < 40; r++) begin
            int hi = $urandom_range(0, 5);
            int lo = $urandom_range(0, 5);
            int n = $urandom_range(0, 4);
            int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            run_train(hi, lo, n, ab, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                chk("gap_idle", 32'(outs()), 32'd0);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
